// File: rtl/light_int_conditioner.sv
// rtl/light_int_conditioner.sv - ambient-light sensor interrupt conditioner
//
// Turns the sensor's held-level interrupt into exactly one clean, fixed-width
// pulse per event for an edge-capturing PIO input. The raw pin is
// synchronized, qualified over FILTER_CYCLES, stretched to STRETCH_CYCLES,
// then held off for at least HOLDOFF_CYCLES and until the line is released
// before the block re-arms.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   int_raw      sensor interrupt pin, asynchronous to clk
//   enable       synchronous enable; 0 forces IDLE and truncates a pulse
//   count_clr    synchronous clear of event_count
//   int_out      conditioned pulse to the PIO in_port (registered)
//   busy         high whenever the FSM is not in IDLE (registered)
//   event_count  qualified events since reset/clear, saturating
//
// Build option: LIGHT_INT_COUNT_EN - when defined, event_count and count_clr
// are implemented; otherwise event_count is tied to 0 and count_clr ignored.

module light_int_conditioner #(
  parameter bit          ACTIVE_LOW     = 1'b1,
  parameter int unsigned FILTER_CYCLES  = 500,
  parameter int unsigned STRETCH_CYCLES = 2500,
  parameter int unsigned HOLDOFF_CYCLES = 50000,
  parameter int          CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             int_raw,
  input  logic             enable,
  input  logic             count_clr,
  output logic             int_out,
  output logic             busy,
  output logic [CNT_W-1:0] event_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_ASSERT  = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] STR_LAST  = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

  // Inactive pin level; the synchronizer powers up "not asserted".
  localparam logic IDLE_LVL = ACTIVE_LOW;

  logic             s1;
  logic             s2;
  logic             asserted;
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] timer_q;
  logic [CNT_W-1:0] timer_d;
  logic             fire;

  // Plain two-flop synchronizer, nothing between the stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= IDLE_LVL;
      s2 <= IDLE_LVL;
    end else begin
      s1 <= int_raw;
      s2 <= s1;
    end
  end

  assign asserted = ACTIVE_LOW ? ~s2 : s2;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    fire    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (asserted) begin
          state_d = ST_QUALIFY;
          timer_d = '0;
        end
      end
      ST_QUALIFY: begin
        if (!asserted) begin
          // Glitch shorter than the filter window: drop it silently.
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (timer_q == FILT_LAST) begin
          state_d = ST_ASSERT;
          timer_d = '0;
          fire    = 1'b1;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      ST_ASSERT: begin
        if (timer_q == STR_LAST) begin
          state_d = ST_HOLDOFF;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      ST_HOLDOFF: begin
        // Timer parks at its last value; a level still held by the sensor
        // keeps us here so one event never produces a second edge.
        if (timer_q == HOLD_LAST) begin
          if (!asserted) begin
            state_d = ST_IDLE;
            timer_d = '0;
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
    if (!enable) begin
      state_d = ST_IDLE;
      timer_d = '0;
      fire    = 1'b0;
    end
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the FSM itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      int_out <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      int_out <= (state_d == ST_ASSERT);
      busy    <= (state_d != ST_IDLE);
    end
  end

`ifdef LIGHT_INT_COUNT_EN
  // Clear has priority over a coincident increment; saturate at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      event_count <= '0;
    end else if (count_clr) begin
      event_count <= '0;
    end else if (fire && (event_count != '1)) begin
      event_count <= event_count + CNT_W'(1);
    end
  end
`else
  logic unused_count_inputs;
  assign unused_count_inputs = count_clr ^ fire;
  assign event_count         = '0;
`endif

endmodule
